// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with zero-latency hit lookup and a
// word-by-word line refill from a ready/request backing memory.
module instr_cache #(
    parameter int WIDTH      = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic             inv,
    output logic [WIDTH-1:0] instr,
    output logic             Stall,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = WIDTH - 2 - WB - IB;
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t          state_q, state_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [TB-1:0]   miss_tag_q, miss_tag_d;
    logic [IB-1:0]   miss_idx_q, miss_idx_d;
    logic [WB-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] data_q [SETS][LINE_WORDS];
    logic [TB-1:0]    tag_q  [SETS];

    logic [WB-1:0] a_word;
    logic [IB-1:0] a_idx;
    logic [TB-1:0] a_tag;
    logic          hit;
    logic          data_we;
    logic          tag_we;
    logic          unused_addr_bits;

    assign a_word = addr[2 +: WB];
    assign a_idx  = addr[2 + WB +: IB];
    assign a_tag  = addr[WIDTH-1 -: TB];
    assign hit    = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        cnt_d      = cnt_q;
        instr      = NOP;
        Stall      = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        data_we    = 1'b0;
        tag_we     = 1'b0;

        // Invalidate first so a completing refill below can still mark its line.
        if (inv) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (hit) begin
                    instr = data_q[a_idx][a_word];
                end else begin
                    Stall      = 1'b1;
                    miss_tag_d = a_tag;
                    miss_idx_d = a_idx;
                    cnt_d      = '0;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                Stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
                if (mem_ready) begin
                    data_we = 1'b1;
                    if (cnt_q == WB'(LINE_WORDS - 1)) begin
                        tag_we              = 1'b1;
                        valid_d[miss_idx_q] = 1'b1;
                        cnt_d               = '0;
                        state_d             = IDLE;
                    end else begin
                        cnt_d = cnt_q + WB'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset masks all outputs and blocks array writes in the same cycle.
        if (rst) begin
            instr    = NOP;
            Stall    = 1'b0;
            mem_req  = 1'b0;
            mem_addr = '0;
            data_we  = 1'b0;
            tag_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[miss_idx_q][cnt_q] <= mem_rdata;
        end
        if (tag_we) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Randomised and directed bench for instr_cache against a line-level cache model
// backed by a fixed memory content function.
module tb_instr_cache;

    localparam int WIDTH = 32;
    localparam int SETS  = 16;
    localparam int LW    = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        inv;
    logic [31:0] instr;
    logic        Stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    instr_cache #(.WIDTH(WIDTH), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .addr(addr), .inv(inv),
        .instr(instr), .Stall(Stall),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model state: a line is identified by its byte base address
    bit          m_busy;
    logic [31:0] m_base;
    int unsigned m_cnt;
    bit          m_valid [SETS];
    logic [31:0] m_line  [SETS];

    int          wait_mode;
    int unsigned wl;
    logic [31:0] acc_q[$];
    logic [31:0] last_instr;
    logic        last_stall;
    logic        last_req;

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return (32'h9C + w) ^ ((a >> 8) * 32'h0101_0000);
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a >> 4) % SETS;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    function automatic int unsigned nwaits();
        if (wait_mode == 1) return 3;
        if (wait_mode == 2) return $urandom_range(0, 2);
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: respond as memory, compare against model, advance model.
    task automatic step();
        bit          hit;
        bit          done;
        int unsigned i;
        @(negedge clk);
        #1;
        if (!mem_req) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            wl = nwaits();
        end else if (wl == 0) begin
            mem_ready = 1'b1;
            mem_rdata = memf(mem_addr);
            wl = nwaits();
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wl--;
        end
        #1;
        last_instr = instr;
        last_stall = Stall;
        last_req   = mem_req;
        i   = idx_of(addr);
        hit = m_valid[i] && (m_line[i] == line_of(addr));
        if (rst) begin
            chk("rst_instr", instr, NOP);
            chk("rst_stall", 32'(Stall), 0);
            chk("rst_req", 32'(mem_req), 0);
            chk("rst_maddr", mem_addr, 0);
        end else if (m_busy) begin
            chk("refill_instr", instr, NOP);
            chk("refill_stall", 32'(Stall), 1);
            chk("refill_req", 32'(mem_req), 1);
            chk("refill_maddr", mem_addr, m_base + 32'(4 * m_cnt));
            if (mem_ready) acc_q.push_back(mem_addr);
        end else begin
            chk("idle_instr", instr, hit ? memf(addr & ~32'h3) : NOP);
            chk("idle_stall", 32'(Stall), hit ? 0 : 1);
            chk("idle_req", 32'(mem_req), 0);
        end
        if (rst) begin
            m_busy = 0;
            m_cnt  = 0;
            foreach (m_valid[k]) m_valid[k] = 0;
        end else begin
            done = 0;
            if (m_busy && mem_ready) begin
                m_cnt++;
                done = (m_cnt == LW);
            end
            if (inv) foreach (m_valid[k]) m_valid[k] = 0;
            if (done) begin
                m_valid[idx_of(m_base)] = 1;
                m_line[idx_of(m_base)]  = m_base;
                m_busy = 0;
            end else if (!m_busy && !hit) begin
                m_busy = 1;
                m_base = line_of(addr);
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, output int unsigned stalls);
        bit done;
        done   = 0;
        stalls = 0;
        addr   = a;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            if (last_stall) stalls++;
            else done = 1;
        end
        if (!done) chk("fetch_timeout", 0, 1);
    endtask

    initial begin
        int unsigned s;
        rst = 1'b1; inv = 1'b0; addr = '0; mem_ready = 1'b0; mem_rdata = '0;
        wait_mode = 0; wl = 0;
        m_busy = 0; m_cnt = 0; m_base = '0;
        foreach (m_valid[k]) begin m_valid[k] = 0; m_line[k] = '0; end
        step();
        step();
        chk("reset_instr_lit", last_instr, NOP);
        chk("reset_stall_lit", 32'(last_stall), 0);
        rst = 1'b0;

        // cold miss at 0x10
        acc_q.delete();
        fetch(32'h10, s);
        chk("cold_stalls", s, 5);
        chk("cold_instr", last_instr, 32'hA0);
        chk("cold_nwords", acc_q.size(), 4);
        for (int k = 0; k < acc_q.size(); k++) chk("cold_maddr", acc_q[k], 32'h10 + 32'(4 * k));

        // hit inside the line, same cycle
        addr = 32'h1C;
        step();
        chk("hit1c_instr", last_instr, 32'hA3);
        chk("hit1c_stall", 32'(last_stall), 0);
        chk("hit1c_req", 32'(last_req), 0);

        // three wait states before each word
        wait_mode = 1;
        fetch(32'h50, s);
        chk("wait_stalls", s, 17);
        chk("wait_instr", last_instr, 32'hB0);
        wait_mode = 0;

        // conflict on index 1
        fetch(32'h110, s);
        chk("conf_stalls", s, 5);
        chk("conf_instr", last_instr, 32'h0101_00E0);
        fetch(32'h10, s);
        chk("conf_back_stalls", s, 5);

        // address move and invalidate during refill of 0x20
        addr = 32'h20;
        step();
        step();
        addr = 32'h40; inv = 1'b1;
        step();
        inv = 1'b0;
        step();
        step();
        step();
        chk("inv_miss40", 32'(last_stall), 1);
        fetch(32'h40, s);
        addr = 32'h24;
        step();
        chk("inv_hit24_stall", 32'(last_stall), 0);
        chk("inv_hit24_instr", last_instr, 32'hA5);
        fetch(32'h10, s);
        chk("inv_miss10", s, 5);

        // reset in the middle of a refill
        rst = 1'b1;
        step();
        rst = 1'b0;
        addr = 32'h24;
        step();
        chk("post_rst_miss", 32'(last_stall), 1);
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_req", 32'(last_req), 0);
        rst = 1'b0;
        acc_q.delete();
        fetch(32'h20, s);
        chk("rerefill_stalls", s, 5);
        chk("rerefill_first", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'h20);
        chk("rerefill_instr", last_instr, 32'hA4);

        // randomised traffic
        wait_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            addr = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            inv  = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        inv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
